// File: rtl/mips_mult_pkg.sv
// Shared constants for the HI/LO multiplier: register-file commands, FSM states
// and the iteration count.
package mips_mult_pkg;

  localparam logic [1:0] MUL_NONE  = 2'd0;
  localparam logic [1:0] MUL_WRITE = 2'd1;
  localparam logic [1:0] MUL_ACC   = 2'd2;

  localparam int MULT_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mult_state_t;

endpackage

// File: rtl/mult_sign_fix.sv
// Conditional two's-complement: passes value_in through, or negates it when
// negate is set. Used for operand magnitudes and the final product sign.
module mult_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value_in,
  input  logic         negate,
  output logic [W-1:0] value_out
);

  assign value_out = negate ? (~value_in + {{(W-1){1'b0}}, 1'b1}) : value_in;

endmodule

// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier feeding the HI/LO register pair.
// Define MULT_SIGNED_EN to honour is_signed; otherwise all operands are unsigned.
module mult_unit
  import mips_mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [1:0]       mul,
  output logic [WIDTH-1:0] write_data_1,
  output logic [WIDTH-1:0] write_data_2
);

  localparam int CW = $clog2(MULT_ITERS);
  localparam logic [CW-1:0] LAST_CNT = CW'(MULT_ITERS - 1);

  mult_state_t        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         mul_q, mul_d;
  logic [WIDTH-1:0]   wd1_q, wd1_d;
  logic [WIDTH-1:0]   wd2_q, wd2_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               neg_in;
  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH-1:0] prod_next, prod_final;
  logic               start_ok;

`ifdef MULT_SIGNED_EN
  mult_sign_fix #(.W(WIDTH)) u_fix_a (
    .value_in (src_a),
    .negate   (is_signed & src_a[WIDTH-1]),
    .value_out(a_mag)
  );

  mult_sign_fix #(.W(WIDTH)) u_fix_b (
    .value_in (src_b),
    .negate   (is_signed & src_b[WIDTH-1]),
    .value_out(b_mag)
  );

  mult_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .value_in (prod_next),
    .negate   (neg_q),
    .value_out(prod_final)
  );

  assign neg_in = is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign a_mag      = src_a;
  assign b_mag      = src_b;
  assign neg_in     = 1'b0;
  assign prod_final = prod_next;
`endif

  // Add into the upper half with a kept carry, then shift {carry, product} right.
  assign upper_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                     (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign prod_next = {upper_sum, prod_q[WIDTH-1:1]};
  assign start_ok  = start && ((op == MUL_WRITE) || (op == MUL_ACC));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mul_d    = MUL_NONE;
    wd1_d    = wd1_q;
    wd2_d    = wd2_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d  = RUN;
          op_d     = op;
          neg_d    = neg_in;
          mcand_d  = a_mag;
          mplier_d = b_mag;
          prod_d   = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        prod_d   = prod_next;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d        = DONE;
          busy_d         = 1'b0;
          done_d         = 1'b1;
          mul_d          = op_q;
          {wd2_d, wd1_d} = prod_final;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= MUL_NONE;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mul_q    <= MUL_NONE;
      wd1_q    <= '0;
      wd2_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mul_q    <= mul_d;
      wd1_q    <= wd1_d;
      wd2_q    <= wd2_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign mul          = mul_q;
  assign write_data_1 = wd1_q;
  assign write_data_2 = wd2_q;

endmodule

// File: tb/tb_mult_unit.sv
// Directed testbench for mult_unit: table of product vectors plus hand-written
// sequences for ignored starts, mid-run reset and back-to-back operation.
module tb_mult_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic        is_signed;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [1:0]  mul;
  logic [31:0] write_data_1;
  logic [31:0] write_data_2;

  int vectors_applied = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0]  op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[7];

  mult_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .is_signed   (is_signed),
    .src_a       (src_a),
    .src_b       (src_b),
    .busy        (busy),
    .done        (done),
    .mul         (mul),
    .write_data_1(write_data_1),
    .write_data_2(write_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Start one operation, then check the busy window, the DONE cycle and the hold cycle.
  task automatic applyStimulus(input vec_t v, input string tag);
    int bad;
    @(negedge clk);
    start = 1'b1; op = v.op; is_signed = v.sgn; src_a = v.a; src_b = v.b;
    @(posedge clk);
    #1 start = 1'b0;
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0 || mul !== 2'd0) bad++;
    end
    checkOutput({tag, ".busy_window"}, 64'(bad), 64'd0);
    @(negedge clk);
    checkOutput({tag, ".done"}, {63'd0, done}, 64'd1);
    checkOutput({tag, ".mul"}, {62'd0, mul}, {62'd0, v.op});
    checkOutput({tag, ".product"}, {write_data_2, write_data_1}, {v.exp_hi, v.exp_lo});
    @(negedge clk);
    checkOutput({tag, ".after_done"}, {60'd0, busy, done, mul}, 64'd0);
    checkOutput({tag, ".hold"}, {write_data_2, write_data_1}, {v.exp_hi, v.exp_lo});
  endtask

  initial begin
    int bad;
    int done_cnt;
    int first_done;
    int second_done;
    logic [63:0] res1;
    logic [63:0] res2;

    vecs[0] = '{2'd1, 1'b0, 32'd3, 32'd5, 32'h0, 32'h0000000F};
    vecs[1] = '{2'd1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
`ifdef MULT_SIGNED_EN
    vecs[2] = '{2'd1, 1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[5] = '{2'd1, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFA, 32'h00000000, 32'd42};
`else
    vecs[2] = '{2'd1, 1'b1, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1};
    vecs[5] = '{2'd1, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFA, 32'hFFFFFFF3, 32'd42};
`endif
    vecs[3] = '{2'd2, 1'b0, 32'd7, 32'd6, 32'h0, 32'd42};
    vecs[4] = '{2'd1, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0};
    vecs[6] = '{2'd1, 1'b0, 32'h0, 32'h12345678, 32'h0, 32'h0};

    rst = 1'b1; start = 1'b0; op = 2'd0; is_signed = 1'b0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset.ctrl", {60'd0, busy, done, mul}, 64'd0);
    checkOutput("reset.data", {write_data_2, write_data_1}, 64'd0);

    // Invalid op codes must not start an operation.
    @(negedge clk);
    start = 1'b1; op = 2'd0; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    op = 2'd3;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || mul !== 2'd0) bad++;
    end
    checkOutput("invalid_op.ignored", 64'(bad), 64'd0);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // A start during RUN with new operands is ignored.
    @(negedge clk);
    start = 1'b1; op = 2'd1; is_signed = 1'b0; src_a = 32'd11; src_b = 32'd13;
    @(posedge clk);
    #1 start = 1'b0;
    done_cnt = 0; first_done = 0; res1 = '0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == 5) begin start = 1'b1; op = 2'd2; src_a = 32'd100; src_b = 32'd200; end
      if (k == 6) start = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done == 0) begin first_done = k; res1 = {write_data_2, write_data_1}; end
      end
    end
    checkOutput("ignore_start.done_count", 64'(done_cnt), 64'd1);
    checkOutput("ignore_start.done_cycle", 64'(first_done), 64'd33);
    checkOutput("ignore_start.product", res1, 64'd143);

    // Reset mid-RUN aborts without any done/mul pulse.
    @(negedge clk);
    start = 1'b1; op = 2'd1; src_a = 32'd21; src_b = 32'd2;
    @(posedge clk);
    #1 start = 1'b0;
    bad = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 10) begin rst = 1'b1; start = 1'b1; end
      if (k == 11) begin
        rst = 1'b0; start = 1'b0;
        checkOutput("mid_reset.ctrl", {60'd0, busy, done, mul}, 64'd0);
        checkOutput("mid_reset.data", {write_data_2, write_data_1}, 64'd0);
      end
      if (done !== 1'b0 || mul !== 2'd0) bad++;
    end
    checkOutput("mid_reset.no_done", 64'(bad), 64'd0);

    // Start held through DONE: second op accepted, done exactly 33 cycles later.
    @(negedge clk);
    start = 1'b1; op = 2'd1; is_signed = 1'b0; src_a = 32'd1000; src_b = 32'd1000;
    @(posedge clk);
    #1;
    first_done = 0; second_done = 0; res1 = '0; res2 = '0;
    for (int k = 1; k <= 75; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (first_done == 0) begin
          first_done = k; res1 = {write_data_2, write_data_1};
          op = 2'd2; src_a = 32'h00010000; src_b = 32'h00010000;
        end else if (second_done == 0) begin
          second_done = k; res2 = {write_data_2, write_data_1};
        end
      end
      if (first_done != 0 && k == first_done + 1) start = 1'b0;
    end
    checkOutput("b2b.first_cycle", 64'(first_done), 64'd33);
    checkOutput("b2b.first_product", res1, 64'd1000000);
    checkOutput("b2b.gap", 64'(second_done - first_done), 64'd33);
    checkOutput("b2b.second_product", res2, 64'h0000000100000000);
    @(negedge clk);
    checkOutput("b2b.idle", {60'd0, busy, done, mul}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
